nap_timer_core: RTL and testbench

NAP_TIMER_CORE -- requirements
Module: nap_timer_core

---
 rtl/nap_timer_core.sv | 174 +++++++++++++++++
 tb/tb_nap_timer_core.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/nap_timer_core.sv
// nap_timer_core: BCD mm:ss countdown timer with a pause/resume FSM, an alarm
// state and a multiplexed 4-digit display scan (registered bNum/dig_sel).
module nap_timer_core #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] bNum,
  output logic [3:0] dig_sel,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t          state_q, state_d;
  logic [3:0]      mt_q, mu_q, st_q, su_q;
  logic [3:0]      mt_d, mu_d, st_d, su_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      dig_sel_q, bnum_q;
  logic            running_q, done_q, alarm_q;

  logic            nonzero, last_sec, tick;

  function automatic logic [3:0] cl9(input logic [3:0] x);
    return (x > 4'd9) ? 4'd9 : x;
  endfunction

  function automatic logic [3:0] pick(input logic [1:0] i, input logic [3:0] d0,
                                      input logic [3:0] d1, input logic [3:0] d2,
                                      input logic [3:0] d3);
    case (i)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  assign nonzero  = |{mt_q, mu_q, st_q, su_q};
  // In RUN the time is never 00:00, so the next decrement reaches zero only from 00:01.
  assign last_sec = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd1);
  assign tick     = (state_q == RUN) && (presc_q == TICK_MAX);

  // Next-state: FSM transitions, prescaler, BCD countdown and display scan.
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mu_d    = mu_q;
    st_d    = st_q;
    su_d    = su_q;
    presc_d = presc_q;
    scan_d  = scan_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE, PAUSE: begin
        if (load) begin
          state_d = IDLE;
          presc_d = '0;
          mt_d    = cl9(set_min[7:4]);
          mu_d    = cl9(set_min[3:0]);
          st_d    = (set_sec[7:4] > 4'd5) ? 4'd5 : set_sec[7:4];
          su_d    = cl9(set_sec[3:0]);
        end else if (start && nonzero) begin
          state_d = RUN;
          // Resuming from PAUSE keeps the partial second already counted.
          if (state_q == IDLE) presc_d = '0;
        end
      end
      RUN: begin
        // The prescaler keeps counting on the pause edge; pause only changes state.
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (su_q != 4'd0) su_d = su_q - 4'd1;
          else begin
            su_d = 4'd9;
            if (st_q != 4'd0) st_d = st_q - 4'd1;
            else begin
              st_d = 4'd5;
              if (mu_q != 4'd0) mu_d = mu_q - 4'd1;
              else begin
                mu_d = 4'd9;
                mt_d = mt_q - 4'd1;
              end
            end
          end
        end
        if (tick && last_sec) state_d = ALARM;
        else if (pause)       state_d = PAUSE;
      end
      ALARM: begin
        if (load) begin
          state_d = IDLE;
          presc_d = '0;
          mt_d    = cl9(set_min[7:4]);
          mu_d    = cl9(set_min[3:0]);
          st_d    = (set_sec[7:4] > 4'd5) ? 4'd5 : set_sec[7:4];
          su_d    = cl9(set_sec[3:0]);
        end else if (start) begin
          state_d = IDLE;
          presc_d = '0;
          mt_d    = 4'd0;
          mu_d    = 4'd0;
          st_d    = 4'd0;
          su_d    = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      scan_d = scan_q + SW'(1);
    end
  end

  // State/datapath registers; outputs registered from next-state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mt_q      <= 4'd0;
      mu_q      <= 4'd0;
      st_q      <= 4'd0;
      su_q      <= 4'd0;
      presc_q   <= '0;
      scan_q    <= '0;
      idx_q     <= 2'd0;
      dig_sel_q <= 4'b0001;
      bnum_q    <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_q      <= mt_d;
      mu_q      <= mu_d;
      st_q      <= st_d;
      su_q      <= su_d;
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dig_sel_q <= 4'b0001 << idx_d;
      bnum_q    <= pick(idx_d, su_d, st_d, mu_d, mt_d);
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == ALARM);
      done_q    <= (state_d == ALARM) && (state_q != ALARM);
    end
  end

  assign bNum    = bnum_q;
  assign dig_sel = dig_sel_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_nap_timer_core.sv
// tb_nap_timer_core: directed scenarios plus random traffic, every cycle
// compared against a seconds-based behavioural model of the timer.
module tb_nap_timer_core;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] set_min = 8'h00, set_sec = 8'h00;
  logic [3:0] bNum, dig_sel;
  logic       running, done, alarm;

  int checks = 0;
  int errors = 0;

  // model state: time as plain seconds
  int mode = M_IDLE, secs = 0, pre = 0, scan = 0, idx = 0, mdone = 0;

  nap_timer_core #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .set_min(set_min), .set_sec(set_sec),
    .start(start), .pause(pause), .bNum(bNum), .dig_sel(dig_sel),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int load_secs(input logic [7:0] m, input logic [7:0] s);
    int mins, sec;
    mins = clamp(int'(m[7:4]), 9) * 10 + clamp(int'(m[3:0]), 9);
    sec  = clamp(int'(s[7:4]), 5) * 10 + clamp(int'(s[3:0]), 9);
    return mins * 60 + sec;
  endfunction

  function automatic int digit_of(input int t, input int i);
    case (i)
      0:       return (t % 60) % 10;
      1:       return (t % 60) / 10;
      2:       return (t / 60) % 10;
      default: return (t / 60) / 10;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic ld, input logic st,
                            input logic pa, input logic [7:0] m, input logic [7:0] s);
    mdone = 0;
    if (!r) begin
      mode = M_IDLE; secs = 0; pre = 0; scan = 0; idx = 0;
      return;
    end
    if (scan == SD - 1) begin scan = 0; idx = (idx + 1) % 4; end
    else scan++;
    if (mode == M_RUN) begin
      if (pre == TD - 1) begin
        pre = 0;
        secs--;
        if (secs == 0) begin mode = M_ALARM; mdone = 1; end
        else if (pa) mode = M_PAUSE;
      end else begin
        pre++;
        if (pa) mode = M_PAUSE;
      end
    end else if (ld) begin
      secs = load_secs(m, s); mode = M_IDLE; pre = 0;
    end else if (st) begin
      if (mode == M_ALARM) begin mode = M_IDLE; secs = 0; pre = 0; end
      else if (secs != 0) begin
        if (mode == M_IDLE) pre = 0;
        mode = M_RUN;
      end
    end
  endtask

  // one clock: drive inputs, advance model on the edge, compare at the falling edge
  task automatic step(input logic r, input logic ld, input logic st, input logic pa,
                      input logic [7:0] m = 8'h00, input logic [7:0] s = 8'h00);
    rst_n = r; load = ld; start = st; pause = pa; set_min = m; set_sec = s;
    @(posedge clk);
    model_edge(r, ld, st, pa, m, s);
    @(negedge clk);
    chk("running", 32'(running), 32'(mode == M_RUN));
    chk("alarm",   32'(alarm),   32'(mode == M_ALARM));
    chk("done",    32'(done),    32'(mdone));
    chk("dig_sel", 32'(dig_sel), 32'(1 << idx));
    chk("bNum",    32'(bNum),    32'(digit_of(secs, idx)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    // reset and start with 00:00: nothing happens
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34);
    chk("rst_dig_sel", 32'(dig_sel), 32'h1);
    chk("rst_bNum", 32'(bNum), 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("start_zero_running", 32'(running), 32'h0);
    idle(2);

    // 00:03 countdown to alarm 12 cycles after RUN entry
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("run_after_start", 32'(running), 32'h1);
    idle(11);
    chk("alarm_early", 32'(alarm), 32'h0);
    idle(1);
    chk("alarm_at_12", 32'(alarm), 32'h1);
    chk("done_at_12", 32'(done), 32'h1);
    idle(1);
    chk("done_single", 32'(done), 32'h0);
    idle(3);
    step(1'b1, 1'b0, 1'b1, 1'b0);   // acknowledge
    chk("ack_alarm", 32'(alarm), 32'h0);

    // clamp: AF/7C -> 99:59
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAF, 8'h7C);
    idle(8);

    // 10:00 -> 09:59 with full borrow chain
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(12);

    // pause holds time and prescaler, resume finishes the partial second
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(20);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h09);   // load ignored? no: PAUSE accepts load
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(6);

    // reset mid-RUN at 05:30
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h30);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);   // load in RUN ignored
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_sel0", 32'(dig_sel), 32'h1);
    chk("mid_rst_run", 32'(running), 32'h0);
    idle(1); chk("mid_rst_sel1", 32'(dig_sel), 32'h1);
    idle(1); chk("mid_rst_sel2", 32'(dig_sel), 32'h2);
    idle(1); chk("mid_rst_sel3", 32'(dig_sel), 32'h2);
    idle(1); chk("mid_rst_sel4", 32'(dig_sel), 32'h4);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, ld, st, pa;
      logic [7:0] m, s;
      r  = ($urandom_range(0, 299) != 0);
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 11) == 0);
      pa = ($urandom_range(0, 29) == 0);
      m  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      s  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      step(r, ld, st, pa, m, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
